// File: rtl/barrel_pkg.sv
// Shared mode and direction encodings for the pipelined barrel rotator.
package barrel_pkg;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSH = 2'b01;
  localparam logic [1:0] MODE_ASH = 2'b10;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/rotator_stage.sv
// One pipeline stage: conditionally moves the word by SHIFT positions and
// registers it together with its sideband under valid/ready flow control.
module rotator_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [AMT_W-1:0] up_amount_i,
  input  logic             up_lr_i,
  input  logic [1:0]       up_mode_i,
  input  logic             up_sign_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o,
  output logic [AMT_W-1:0] dn_amount_o,
  output logic             dn_lr_o,
  output logic [1:0]       dn_mode_o,
  output logic             dn_sign_o
);

  localparam int BIT = $clog2(SHIFT);

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] amount_q;
  logic             lr_q, sign_q;
  logic [1:0]       mode_q;
  logic             is_rot, is_ash;
  logic [SHIFT-1:0] left_fill, right_fill;

  // The reserved mode 11 behaves as rotate.
  always_comb begin
    is_rot     = (up_mode_i == MODE_ROT) || (up_mode_i == 2'b11);
    is_ash     = (up_mode_i == MODE_ASH);
    left_fill  = is_rot ? up_data_i[WIDTH-1 -: SHIFT] : {SHIFT{1'b0}};
    right_fill = is_rot ? up_data_i[SHIFT-1:0]
               : ((is_ash && up_sign_i) ? {SHIFT{1'b1}} : {SHIFT{1'b0}});
    data_d     = up_data_i;
    if (up_amount_i[BIT]) begin
      if (up_lr_i == DIR_LEFT) data_d = {up_data_i[WIDTH-SHIFT-1:0], left_fill};
      else                     data_d = {right_fill, up_data_i[WIDTH-1:SHIFT]};
    end
  end

  assign up_ready_o = !valid_q || dn_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amount_q <= '0;
      lr_q     <= 1'b0;
      mode_q   <= 2'b00;
      sign_q   <= 1'b0;
    end else if (up_ready_o) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q   <= data_d;
        amount_q <= up_amount_i;
        lr_q     <= up_lr_i;
        mode_q   <= up_mode_i;
        sign_q   <= up_sign_i;
      end
    end
  end

  assign dn_valid_o  = valid_q;
  assign dn_data_o   = data_q;
  assign dn_amount_o = amount_q;
  assign dn_lr_o     = lr_q;
  assign dn_mode_o   = mode_q;
  assign dn_sign_o   = sign_q;

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined WIDTH-bit rotator/shifter: log2(WIDTH) stages, stage k moves by 2^k,
// with full valid/ready backpressure and collapsing bubbles.
module pipelined_barrel_rotator
  import barrel_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int AMT_W  = $clog2(WIDTH),
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             v      [STAGES+1];
  logic             rdy    [STAGES+1];
  logic [WIDTH-1:0] d      [STAGES+1];
  logic [AMT_W-1:0] amt    [STAGES+1];
  logic             lr     [STAGES+1];
  logic [1:0]       mode   [STAGES+1];
  logic             sign   [STAGES+1];
  logic             unused_sideband;

  assign v[0]    = in_valid;
  assign d[0]    = in_data;
  assign amt[0]  = in_amount;
  assign lr[0]   = in_lr;
  assign mode[0] = in_mode;
  assign sign[0] = in_data[WIDTH-1];

  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rotator_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k),
      .AMT_W (AMT_W)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .up_valid_i  (v[k]),
      .up_ready_o  (rdy[k]),
      .up_data_i   (d[k]),
      .up_amount_i (amt[k]),
      .up_lr_i     (lr[k]),
      .up_mode_i   (mode[k]),
      .up_sign_i   (sign[k]),
      .dn_valid_o  (v[k+1]),
      .dn_ready_i  (rdy[k+1]),
      .dn_data_o   (d[k+1]),
      .dn_amount_o (amt[k+1]),
      .dn_lr_o     (lr[k+1]),
      .dn_mode_o   (mode[k+1]),
      .dn_sign_o   (sign[k+1])
    );
  end

  // Sideband leaving the last stage has no consumer.
  assign unused_sideband = ^{amt[STAGES], lr[STAGES], mode[STAGES], sign[STAGES]};

  assign in_ready  = rdy[0] && !reset;
  assign out_valid = v[STAGES];
  assign out_data  = d[STAGES];

endmodule

// File: doc/pipelined_barrel_rotator.md
Name: pipelined_barrel_rotator

Overview:
Parametrised, pipelined successor to the combinational 8-bit bidirectional rotator. It rotates or shifts a WIDTH-bit word left or right by 0..WIDTH-1 positions, with three modes: rotate, logical shift and arithmetic shift. The shifter is split into log2(WIDTH) registered stages, each moving the word by 2^k positions. It sits between a valid/ready producer and consumer in the datapath and supports full backpressure.

Parameters:
WIDTH, 8, data width; power of 2, >= 2
AMT_W, $clog2(WIDTH), derived amount width; not overridden by users
STAGES, $clog2(WIDTH), derived pipeline depth; not overridden by users

Ports:
clk  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input transaction valid
in_ready  output  1  block accepts the input this cycle
in_data  input  WIDTH  word to rotate/shift
in_amount  input  AMT_W  shift distance
in_lr  input  1  direction: 1 = left, 0 = right
in_mode  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved (treated as rotate)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  result word

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready is true at that interface. in_data, in_amount, in_lr and in_mode are sampled only on an input transfer. out_data is held stable while out_valid=1 && out_ready=0.
- Pipeline: stage k (k = 0..STAGES-1) holds v_k, data_k, the remaining amount bits, lr, mode and sign.
  - sign = in_data[WIDTH-1], captured at the input.
  - Stage k shifts by 2^k when amount bit k = 1; otherwise it passes the word through unchanged.
  - The last stage drives out_valid and out_data directly from its registers.
- Fill rules per stage:
  - Rotate: bits shifted out re-enter at the opposite end.
  - Logical: zero fill.
  - Arithmetic right: fill with the captured sign bit.
  - Arithmetic left: zero fill, identical to logical left.
- Flow control: ready_k = !v_k || ready_{k+1}, where ready_STAGES = out_ready. in_ready = ready_0 (combinational). Each stage loads when it is ready and transfers when its upstream is valid. Bubbles collapse, so a stalled output does not block stages that are empty.
- Latency: STAGES cycles from input transfer to out_valid with no stall. Throughput is 1 word/cycle when out_ready is held at 1.
- amount = 0: data passes through unchanged in every mode, with the same latency.
- Max amount (WIDTH-1): result follows the fill rules above; nothing wraps past WIDTH.
- Reset:
  - All v_k and out_valid clear to 0 on the cycle reset is sampled high, even mid-transaction; in-flight words are discarded.
  - out_data and all data registers reset to 0.
  - in_ready = 0 while reset is high, and equals 1 on the first cycle after reset deasserts.
- Simultaneous events: with the output stalled and the pipeline full, in_ready = 0. When out_ready rises, every stage advances in the same cycle and in_ready = 1 in that cycle.
- WIDTH=8 equivalence: with mode=00 and out_ready tied to 1, the result matches the original combinational rotator delayed by 3 cycles.

Decomposition:
- Shared package barrel_pkg:
  - mode constants MODE_ROT=2'b00, MODE_LSH=2'b01, MODE_ASH=2'b10
  - direction constants DIR_LEFT=1, DIR_RIGHT=0
- One natural sub-module: rotator_stage, parameterised by WIDTH and SHIFT (= 2^k).
  - Contains: the combinational conditional shift/fill plus the registered valid/data/sideband with its local ready logic.
  - The top level instantiates it STAGES times through a generate loop.

Test Plan:
- WIDTH=8, out_ready=1, data=8'b10010010, lr=1, mode=rot, amount 0..7 streamed back-to-back -> out_data sequence 10010010, 00100101, 01001010, 10010100, 00101001, 01010010, 10100100, 01001001; first result 3 cycles after the first input, then one result per cycle.
- Same data, lr=0, amount=3 -> rot 01010010; lsh 00010010; ash 11110010. lr=1, ash, amount=3 -> 10010000.
- Backpressure: stream 6 words with out_ready=0 -> in_ready drops after 3 accepted (pipeline full). Raise out_ready -> all words delivered in order, none lost or duplicated, and out_data held stable during the stall.
- Bubbles: in_valid toggled randomly with out_ready=1 -> outputs match a reference model, in order, each exactly STAGES cycles after its input.
- Reset mid-stream: assert reset for 1 cycle with 2 words in flight -> out_valid=0 the next cycle, neither word ever emitted, in_ready=1 after reset deasserts.
- WIDTH=32 regression: random data/amount/lr/mode (including amount=0 and amount=31) against a reference model -> exact match, latency 5.
